// File: rtl/ring_fifo_pkg.sv
// ring_fifo_pkg: shared flag type, reset constants and pointer arithmetic for ring_fifo
package ring_fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } flags_t;

    localparam flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
    localparam logic   ERR_RST   = 1'b0;

    // Occupancy from wrap-bit pointers; callers truncate to ADDR_WIDTH+1 bits for the modulo
    function automatic logic [31:0] ptr_count(input logic [31:0] wr, input logic [31:0] rd);
        return wr - rd;
    endfunction

endpackage

// File: rtl/ring_fifo_mem.sv
// ring_fifo_mem: simple dual-port RAM, synchronous write, registered read returning old data on collision
module ring_fifo_mem
    import ring_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write and registered read share one edge so a colliding read sees the old word
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ring_fifo.sv
// ring_fifo: power-of-two circular-buffer FIFO with occupancy, threshold flags and sticky errors; define RING_FIFO_FWFT_EN for first-word-fall-through output
module ring_fifo
    import ring_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH         = 16,
    parameter int DATA_WIDTH         = 32,
    parameter int ALMOST_FULL_LEVEL  = FIFO_DEPTH - 2,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                          clk,
    input  logic                          clear_n,
    input  logic                          flush,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  push_ok, pop_ok, rd_en, udf_evt, loaded;
    flags_t                flags, flags_nxt;

    assign push_ok   = push & ~flags.full;
    assign wr_nxt    = flush ? '0 : wr_ptr + (push_ok ? ONE : '0);
    assign rd_nxt    = flush ? '0 : rd_ptr + (pop_ok ? ONE : '0);
    assign cnt_nxt   = (ADDR_WIDTH + 1)'(ptr_count(32'(wr_nxt), 32'(rd_nxt)));
    assign flags_nxt = '{full: cnt_nxt == DEPTH_C, empty: cnt_nxt == '0,
                         almost_full: cnt_nxt >= AF_C, almost_empty: cnt_nxt <= AE_C};

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;
    assign out_data     = loaded ? rd_data : '0;

`ifdef RING_FIFO_FWFT_EN
    logic [ADDR_WIDTH:0] fe_ptr;
    logic                fetch;

    assign pop_ok  = pop & out_valid;
    assign udf_evt = pop & ~out_valid;
    assign fetch   = (fe_ptr != wr_ptr) & (~out_valid | pop);
    assign rd_en   = fetch & ~flush;
    assign rd_addr = fe_ptr[ADDR_WIDTH-1:0];

    // Head stage: RAM read register holds the oldest word, refilled when empty or consumed
    always_ff @(posedge clk or negedge clear_n)
        if (!clear_n) begin
            fe_ptr    <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            fe_ptr    <= '0;
            out_valid <= 1'b0;
        end else begin
            fe_ptr    <= fe_ptr + (fetch ? ONE : '0);
            out_valid <= fetch | (out_valid & ~pop_ok);
        end
`else
    assign pop_ok  = pop & ~flags.empty;
    assign udf_evt = pop & flags.empty;
    assign rd_en   = pop_ok & ~flush;
    assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    // One-cycle read latency: valid pulses for each accepted pop
    always_ff @(posedge clk or negedge clear_n)
        if (!clear_n)
            out_valid <= 1'b0;
        else
            out_valid <= pop_ok & ~flush;
`endif

    // Pointers, flags and sticky errors, all registered from next-state pointers
    always_ff @(posedge clk or negedge clear_n)
        if (!clear_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            flags     <= FLAGS_RST;
            overflow  <= ERR_RST;
            underflow <= ERR_RST;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            count     <= cnt_nxt;
            flags     <= flags_nxt;
            overflow  <= ~flush & (overflow | (push & flags.full));
            underflow <= ~flush & (underflow | udf_evt);
        end

    // out_data reads as zero until the RAM read register has been loaded after reset
    always_ff @(posedge clk or negedge clear_n)
        if (!clear_n)
            loaded <= 1'b0;
        else if (rd_en)
            loaded <= 1'b1;

    ring_fifo_mem #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH), .AW(ADDR_WIDTH)) u_mem (
        .clk     (clk),
        .wr_en   (push_ok & ~flush),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_ring_fifo.sv
// tb_ring_fifo: scoreboard bench for ring_fifo in standard (non-FWFT) mode against a queue model
module tb_ring_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 32;

    logic          clk = 1'b0, clear_n = 1'b0, flush = 1'b0, push = 1'b0, pop = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]    count;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_out = '0;
    bit            m_ovf, m_udf;
    int            n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    ring_fifo #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk(clk), .clear_n(clear_n), .flush(flush), .push(push), .in_data(in_data), .pop(pop),
        .out_data(out_data), .out_valid(out_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour at each clock edge, expressed as queue operations
    task automatic step(input bit p, input bit r, input bit f, input logic [DW-1:0] d);
        bit was_full, was_empty;
        push = p; pop = r; flush = f; in_data = d;
        @(posedge clk);
        if (f) begin
            q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            was_full  = q.size() == DEPTH;
            was_empty = q.size() == 0;
            if (r && !was_empty) exp_q.push_back(q.pop_front());
            if (p && !was_full) q.push_back(d);
            if (p && was_full) m_ovf = 1;
            if (r && was_empty) m_udf = 1;
        end
        #1;
    endtask

    task automatic reset_pulse();
        push = 0; pop = 0; flush = 0;
        clear_n = 1'b0;
        q.delete(); exp_q.delete(); last_out = '0; m_ovf = 0; m_udf = 0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        @(posedge clk);
        #1;
        clear_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever a read word is due and checks status against the model
    always @(negedge clk) if (clear_n) begin
        chk("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            last_out = exp_q.pop_front();
            chk("out_data", out_data, last_out);
        end else
            chk("out_hold", out_data, last_out);
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("almost_full", almost_full, q.size() >= DEPTH - 2);
        chk("almost_empty", almost_empty, q.size() <= 2);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_udf);
    end

    initial begin
        @(posedge clk);
        #1;
        reset_pulse();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h11 + i);
        for (int i = 0; i < 4; i++) step(0, 1, 0, '0);
        step(0, 0, 0, '0);
        for (int i = 0; i < 17; i++) step(1, 0, 0, $urandom);
        chk("ovf_after_17", overflow, 1);
        chk("full_after_17", full, 1);
        for (int i = 0; i < 16; i++) step(0, 1, 0, '0);
        step(0, 0, 1, '0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, $urandom);
        step(1, 0, 1, $urandom);
        chk("flush_count", count, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, $urandom);
        for (int i = 0; i < 40; i++) step(1, 1, 0, $urandom);
        for (int i = 0; i < 8; i++) step(0, 1, 0, '0);
        step(1, 1, 0, 32'hABCD0001);
        chk("pp_empty_count", count, 1);
        chk("pp_empty_udf", underflow, 1);
        step(0, 0, 1, '0);
        for (int i = 0; i < 16; i++) step(1, 0, 0, $urandom);
        step(1, 1, 0, 32'hABCD0002);
        chk("pp_full_count", count, 15);
        chk("pp_full_ovf", overflow, 1);
        for (int i = 0; i < 15; i++) step(0, 1, 0, '0);
        step(0, 0, 1, '0);
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 100; i++)
                step($urandom_range(0, 3) < (b[0] ? 3 : 1), $urandom_range(0, 3) < (b[0] ? 1 : 3),
                     $urandom_range(0, 63) == 0, $urandom);
        for (int i = 0; i < 6; i++) step(1, i[0], 0, $urandom);
        reset_pulse();
        for (int i = 0; i < 3; i++) step(1, 0, 0, $urandom);
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
        step(0, 0, 0, '0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
